// File: rtl/multiport_regfile_ckpt_pkg.sv
// Shared helpers for the checkpointed multi-port register file:
// width derivation, default checkpoint id type and assertion messages.
package regfile_pkg;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned cw_of(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    localparam int unsigned NCKPT_DFLT = 2;
    typedef logic [cw_of(NCKPT_DFLT)-1:0] ckpt_id_t;

    localparam string MSG_SAVE_FULL    = "regfile: save_call while no checkpoint slot is free";
    localparam string MSG_RESTORE_FREE = "regfile: restore from an unallocated checkpoint slot";

endpackage

// File: rtl/multiport_regfile_ckpt_if.sv
// Read/write/checkpoint bus of the register file; master = rename logic, slave = regfile.
interface multiport_regfile_ckpt_if
    import regfile_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned NREGS = 4,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    parameter int unsigned NCKPT = 2
);
    localparam int unsigned AW = clog2(NREGS);
    localparam int unsigned CW = cw_of(NCKPT);

    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NWR-1:0]    wr_call;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              save_call;
    logic              save_rdy;
    logic [CW-1:0]     save_id;
    logic              restore_call;
    logic [CW-1:0]     restore_id;
    logic              free_call;
    logic [CW-1:0]     free_id;

    modport master (
        output rd_addr, wr_call, wr_addr, wr_data,
        output save_call, restore_call, restore_id, free_call, free_id,
        input  rd_data, save_rdy, save_id
    );

    modport slave (
        input  rd_addr, wr_call, wr_addr, wr_data,
        input  save_call, restore_call, restore_id, free_call, free_id,
        output rd_data, save_rdy, save_id
    );
endinterface

// File: rtl/multiport_regfile_ckpt_alloc.sv
// Checkpoint slot allocator: free bitmap, lowest-free encoder, alloc/free update.
module ckpt_alloc
    import regfile_pkg::*;
#(
    parameter int unsigned NCKPT = 2,
    localparam int unsigned CW   = cw_of(NCKPT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             save_call_i,
    input  logic             free_call_i,
    input  logic [CW-1:0]    free_id_i,
    output logic             save_rdy_c_o,
    output logic [CW-1:0]    save_id_c_o,
    output logic             save_ok_c_o,
    output logic [NCKPT-1:0] free_map_o
);
    logic [NCKPT-1:0] free_q;
    logic [NCKPT-1:0] free_d;
    logic             free_ok;

    assign free_ok      = 32'(free_id_i) < NCKPT;
    assign save_rdy_c_o = |free_q;
    assign free_map_o   = free_q;

    // Lowest free slot index (0 when none free).
    always_comb begin
        save_id_c_o = '0;
        for (int i = int'(NCKPT) - 1; i >= 0; i--) begin
            if (free_q[i]) save_id_c_o = CW'(i);
        end
    end

    // A save colliding with a free of the same id is dropped; the free wins.
    assign save_ok_c_o = save_call_i && save_rdy_c_o &&
                         !(free_call_i && (free_id_i == save_id_c_o));

    // Next free bitmap: allocate first, then release.
    always_comb begin
        free_d = free_q;
        if (save_ok_c_o) free_d[save_id_c_o] = 1'b0;
        if (free_call_i && free_ok) free_d[free_id_i] = 1'b1;
    end

    // Bitmap register; every slot free out of reset.
    always_ff @(posedge clk) begin
        if (reset) free_q <= '1;
        else       free_q <= free_d;
    end
endmodule

// File: rtl/multiport_regfile_ckpt.sv
// Multi-read/multi-write register file with checkpoint slots for rename/commit map tables.
// Optional RF_RD_BYPASS_EN: reads see this cycle's writes/restore combinationally.
module multiport_regfile_ckpt
    import regfile_pkg::*;
#(
    parameter int unsigned   DW        = 8,
    parameter int unsigned   NREGS     = 4,
    parameter int unsigned   NRD       = 2,
    parameter int unsigned   NWR       = 2,
    parameter int unsigned   NCKPT     = 2,
    parameter logic [DW-1:0] RESET_VAL = '0
) (
    input logic                      clk,
    input logic                      reset,
    multiport_regfile_ckpt_if.slave  bus
);
    localparam int unsigned AW = clog2(NREGS);
    localparam int unsigned CW = cw_of(NCKPT);

    logic [DW-1:0]    regs_q [NREGS];
    logic [DW-1:0]    regs_d [NREGS];
    logic [DW-1:0]    rd_src [NREGS];
    logic [DW-1:0]    snap_q [NCKPT][NREGS];
    logic             save_rdy;
    logic [CW-1:0]    save_id;
    logic             save_ok;
    logic [NCKPT-1:0] free_map;
    logic             restore_ok;

    ckpt_alloc #(.NCKPT(NCKPT)) u_alloc (
        .clk          (clk),
        .reset        (reset),
        .save_call_i  (bus.save_call),
        .free_call_i  (bus.free_call),
        .free_id_i    (bus.free_id),
        .save_rdy_c_o (save_rdy),
        .save_id_c_o  (save_id),
        .save_ok_c_o  (save_ok),
        .free_map_o   (free_map)
    );

    assign bus.save_rdy = save_rdy;
    assign bus.save_id  = save_id;
    assign restore_ok   = 32'(bus.restore_id) < NCKPT;

    // Next table: writes in ascending port order (highest wins), restore overrides all.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned p = 0; p < NWR; p++) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                if (bus.wr_call[p] && (bus.wr_addr[p*AW +: AW] == AW'(r)))
                    regs_d[r] = bus.wr_data[p*DW +: DW];
            end
        end
        if (bus.restore_call && restore_ok) regs_d = snap_q[bus.restore_id];
    end

    // Read source: bypassed next-state or registered table.
    always_comb begin
`ifdef RF_RD_BYPASS_EN
        rd_src = regs_d;
`else
        rd_src = regs_q;
`endif
    end

    // Combinational read ports; out-of-range addresses return zero.
    always_comb begin
        bus.rd_data = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            if (32'(bus.rd_addr[p*AW +: AW]) < NREGS)
                bus.rd_data[p*DW +: DW] = rd_src[bus.rd_addr[p*AW +: AW]];
        end
    end

    // Table and snapshot registers; a snapshot captures the post-write/restore table.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= RESET_VAL;
            for (int unsigned c = 0; c < NCKPT; c++)
                for (int unsigned r = 0; r < NREGS; r++) snap_q[c][r] <= RESET_VAL;
        end else begin
            regs_q <= regs_d;
            if (save_ok) snap_q[save_id] <= regs_d;
        end
    end

    // Protocol checks: save with no free slot, restore from a free slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (bus.save_call) assert (save_rdy) else $warning("%s", MSG_SAVE_FULL);
            if (bus.restore_call && restore_ok)
                assert (!free_map[bus.restore_id]) else $warning("%s", MSG_RESTORE_FREE);
        end
    end
endmodule

// File: doc/multiport_regfile_ckpt.md
Name: multiport_regfile_ckpt

Overview:
Parametrised multi-read, multi-write register file with checkpoint (snapshot/restore) slots.
- Used by rename/commit logic as the architectural or speculative map table.
- On a branch, the full table is saved into a checkpoint slot.
- On a mispredict, the table is restored from that slot in one cycle.
- Generalises the single-port register file: width, depth, port counts and reset value are parameters; it adds write-priority rules and checkpointing.

Parameters:
DW, 8, data width of each entry
NREGS, 4, number of entries (>=2); AW = clog2(NREGS)
NRD, 2, number of combinational read ports
NWR, 2, number of write ports
NCKPT, 2, number of checkpoint slots (>=1); CW = max(1, clog2(NCKPT))
RESET_VAL, 0, reset value of every entry (DW bits)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rd_addr  in  NRD*AW  read addresses, port p in bits [p*AW +: AW]
rd_data  out  NRD*DW  read data, port p in bits [p*DW +: DW]
wr_call  in  NWR  per-port write enable
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*DW  write data
save_call  in  1  take a checkpoint this cycle
save_rdy  out  1  at least one slot free
save_id  out  CW  slot that a save this cycle allocates (lowest free index)
restore_call  in  1  restore table from restore_id
restore_id  in  CW  slot to restore
free_call  in  1  release slot free_id
free_id  in  CW  slot to release

Behaviour:
Interface clocking: reset is synchronous and active-high; the clock is clk.

Reset:
- All entries are set to RESET_VAL.
- All slots are marked free; slot contents are set to RESET_VAL.
- save_rdy=1 and save_id=0 in the cycle after reset.

Write path (compute next-state value nxt[r]):
- Start from regs[r].
- Apply write ports in ascending index; a port hits r when wr_call[p] && wr_addr==r.
- The highest-index port wins on an address collision.
- Write addresses >= NREGS are ignored.

Restore:
- If restore_call is high, nxt := snapshot[restore_id], overriding all writes that cycle.
- restore_id of an unallocated slot is a protocol error (simulation assertion); the data is still copied.
- Restore does not free the slot.

Update and read:
- regs <= nxt at the clock edge. Write-to-read latency is 1 cycle.
- rd_data[p] = regs[rd_addr[p]], combinational. An out-of-range address reads 0.

Save:
- When save_call && save_rdy: snapshot[save_id] <= nxt and the slot is marked allocated.
- The snapshot therefore includes same-cycle writes and restore.
- save_call with save_rdy=0 is ignored and flagged by assertion.

Allocation outputs:
- save_rdy = |free_bitmap, taken from the registered bitmap only.
- save_id = lowest set bit of free_bitmap.

Free:
- free_call marks free_id free at the edge.
- A slot freed in cycle t is allocatable from t+1.
- Freeing an already-free slot is a no-op.

Simultaneous save and free of the same id:
- Legal only if that id is allocated.
- Result: the save is ignored (cannot happen, since save_id is free) and the free is applied.

Simultaneous save and restore:
- Both are applied. The new slot holds the restored table.

Reset mid-operation:
- Reset overrides all calls in that cycle.

Optional Feature:
RF_RD_BYPASS_EN
- Defined: rd_data[p] = nxt[rd_addr[p]] (combinational write/restore bypass; restore has priority, then the highest write port).
- Undefined: reads return registered regs only.
- Save, restore and free behaviour is identical either way.

Decomposition:
- Package regfile_pkg holds:
  - function clog2
  - localparams AW/CW derivation helper
  - typedef ckpt_id_t sized from NCKPT
  - assertion message constants
- Sub-module ckpt_alloc holds the free bitmap register, the lowest-free priority encoder (save_id/save_rdy), and the alloc/free update.
- The data array and write-priority logic stay in the top module.

Test Plan:
- Reset, then read all 4 addresses -> rd_data=0 on both ports. Then save_rdy=1, save_id=0.
- Write ports 0 and 1 both to addr 2 with 0x11 and 0x22 -> next cycle, a read of addr2 = 0x22 (port 1 wins). Addr 3 unchanged (0).
- Write addr1=0x5A together with save_call -> slot 0 is allocated and save_id becomes 1. Then write addr1=0xFF, then restore_id=0 -> read addr1=0x5A the cycle after the restore.
- Save twice (slots 0, 1) -> save_rdy=0. A third save_call is ignored. free_id=1 -> save_rdy=1 and save_id=1 the next cycle, not the same cycle.
- Restore slot 0 in the same cycle as a write of addr0=0x77 -> addr0 holds the snapshot value, not 0x77.
- With RF_RD_BYPASS_EN: write addr3=0x3C and read addr3 in the same cycle -> rd_data=0x3C combinationally. Without the macro, rd_data=old value (0).
